// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: forwarding select encoding.
package hazard_pkg;

  localparam int unsigned FWD_SEL_W = 2;

  typedef enum logic [FWD_SEL_W-1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Single-operand forwarding comparator: Memory stage beats Writeback, x0 never forwarded.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_e_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m_i,
  input  logic                      regwrite_m_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w_i,
  input  logic                      regwrite_w_i,
  output fwd_sel_t                  sel_o
);

  // Priority select of the youngest in-flight producer.
  always_comb begin
    sel_o = FWD_REG;
    if (regwrite_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
      sel_o = FWD_M;
    end else if (regwrite_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
      sel_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit: operand forwarding, load-use and multi-cycle scoreboard stalls,
// branch flushes and a saturating stall-cycle counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned NUM_SRC        = 2,
  parameter int unsigned MC_LAT         = 4,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] rs_d,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] rs_e,
  input  logic [REG_ADDR_WIDTH-1:0]         rd_d,
  input  logic                              regwrite_d,
  input  logic                              mc_d,
  input  logic                              valid_d,
  input  logic [REG_ADDR_WIDTH-1:0]         rd_e,
  input  logic                              memread_e,
  input  logic [REG_ADDR_WIDTH-1:0]         rd_m,
  input  logic                              regwrite_m,
  input  logic [REG_ADDR_WIDTH-1:0]         rd_w,
  input  logic                              regwrite_w,
  input  logic                              branch_taken_e,
  output logic [2*NUM_SRC-1:0]              forward_e,
  output logic                              stall_f,
  output logic                              stall_d,
  output logic                              flush_d,
  output logic                              flush_e,
  output logic                              mc_busy,
  output logic [CNT_WIDTH-1:0]              stall_cycles
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam int unsigned SB_W     = $clog2(MC_LAT + 1);

  logic [SB_W-1:0]      sb_q [NUM_REGS];
  logic [SB_W-1:0]      sb_d [NUM_REGS];
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic load_use, mc_raw, mc_waw, mc_struct, hazard, issue;

  // One forwarding comparator per Execute source operand.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
    fwd_sel_t sel;
    hazard_fwd_sel #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd (
      .rs_e_i       (rs_e[gi*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
      .rd_m_i       (rd_m),
      .regwrite_m_i (regwrite_m),
      .rd_w_i       (rd_w),
      .regwrite_w_i (regwrite_w),
      .sel_o        (sel)
    );
    assign forward_e[2*gi +: 2] = 2'(sel);
  end

  // Any pending multi-cycle writeback keeps the unpipelined unit busy.
  always_comb begin
    mc_busy = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (sb_q[r] != '0) mc_busy = 1'b1;
    end
  end

  // Decode-operand hazard detection against the load in Execute and the scoreboard.
  always_comb begin
    logic [REG_ADDR_WIDTH-1:0] src;
    load_use = 1'b0;
    mc_raw   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src = rs_d[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      if (valid_d && (src != '0)) begin
        if (memread_e && (rd_e != '0) && (rd_e == src)) load_use = 1'b1;
        if (sb_q[src] != '0) mc_raw = 1'b1;
      end
    end
    mc_waw    = valid_d && regwrite_d && (rd_d != '0) && (sb_q[rd_d] != '0);
    mc_struct = valid_d && mc_d && mc_busy;
    hazard    = load_use || mc_raw || mc_waw || mc_struct;
  end

  // Pipeline control: a taken branch discards Decode, so it overrides any stall.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    if (branch_taken_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (hazard) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign issue = valid_d && mc_d && regwrite_d && (rd_d != '0) && !stall_d && !branch_taken_e;

  // Scoreboard next state: count down pending entries, load on multi-cycle issue.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      sb_d[r] = (sb_q[r] != '0) ? sb_q[r] - SB_W'(1) : '0;
    end
    if (issue) sb_d[rd_d] = SB_W'(MC_LAT);
  end

  // Saturating stall-cycle counter next state.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_d && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  // State registers; reset drops every pending entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) sb_q[r] <= '0;
      cnt_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) sb_q[r] <= sb_d[r];
      cnt_q <= cnt_d;
    end
  end

  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (small counter to reach saturation).
module tb_hazard_scoreboard;

  localparam int unsigned RAW = 5;
  localparam int unsigned NS  = 2;
  localparam int unsigned CW  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS*RAW-1:0] rs_d, rs_e;
  logic [RAW-1:0]    rd_d, rd_e, rd_m, rd_w;
  logic              regwrite_d, mc_d, valid_d, memread_e, regwrite_m, regwrite_w, branch_taken_e;
  logic [2*NS-1:0]   forward_e;
  logic              stall_f, stall_d, flush_d, flush_e, mc_busy;
  logic [CW-1:0]     stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  hazard_scoreboard #(
    .REG_ADDR_WIDTH(RAW), .NUM_SRC(NS), .MC_LAT(4), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rs_e(rs_e), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .mc_d(mc_d), .valid_d(valid_d), .rd_e(rd_e),
    .memread_e(memread_e), .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w),
    .regwrite_w(regwrite_w), .branch_taken_e(branch_taken_e), .forward_e(forward_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .mc_busy(mc_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    rs_d = '0; rs_e = '0; rd_d = '0; rd_e = '0; rd_m = '0; rd_w = '0;
    regwrite_d = 0; mc_d = 0; valid_d = 0; memread_e = 0;
    regwrite_m = 0; regwrite_w = 0; branch_taken_e = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic ctl(input string tag, input logic sf, input logic sd, input logic fd, input logic fe);
    check({tag, "_stall_f"}, 32'(stall_f), 32'(sf));
    check({tag, "_stall_d"}, 32'(stall_d), 32'(sd));
    check({tag, "_flush_d"}, 32'(flush_d), 32'(fd));
    check({tag, "_flush_e"}, 32'(flush_e), 32'(fe));
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #1;
    check("rst_mc_busy", 32'(mc_busy), 0);
    check("rst_stall_cycles", 32'(stall_cycles), 0);
    ctl("rst", 0, 0, 0, 0);
    #10;
    rst_n = 1'b1;
    step();

    // Forwarding priority and x0 exclusion
    rd_m = 5; regwrite_m = 1; rd_w = 5; regwrite_w = 1; rs_e = {5'd0, 5'd5};
    #1 check("fwd_m_op0", 32'(forward_e), 32'b0010);
    rs_e = {5'd5, 5'd5};
    #1 check("fwd_m_both", 32'(forward_e), 32'b1010);
    regwrite_m = 0;
    #1 check("fwd_w_both", 32'(forward_e), 32'b0101);
    rs_e = {5'd3, 5'd5}; rd_m = 3; regwrite_m = 1;
    #1 check("fwd_mixed", 32'(forward_e), 32'b1001);
    rs_e = '0; rd_m = 0; rd_w = 0;
    #1 check("fwd_x0", 32'(forward_e), 32'b0000);
    clear_inputs();

    // Load-use stall for one cycle
    rd_e = 7; memread_e = 1; rs_d = {5'd7, 5'd0}; valid_d = 1;
    #1 ctl("lu", 1, 1, 0, 1);
    step();
    memread_e = 0; rd_e = 0;
    #1 ctl("lu_after", 0, 0, 0, 0);
    check("lu_cnt", 32'(stall_cycles), 1);

    // Multi-cycle RAW: issue rd9 then dependent reader
    do_reset();
    valid_d = 1; mc_d = 1; regwrite_d = 1; rd_d = 9;
    #1 check("mc_issue_nostall", 32'(stall_d), 0);
    step();
    mc_d = 0; rd_d = 10; rs_d = {5'd0, 5'd9};
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("raw_stall%0d", k), 32'(stall_d), 1);
      check($sformatf("raw_busy%0d", k), 32'(mc_busy), 1);
      step();
    end
    #1 check("raw_release", 32'(stall_d), 0);
    check("raw_busy_clear", 32'(mc_busy), 0);
    check("raw_cnt", 32'(stall_cycles), 4);

    // Back-to-back multi-cycle ops: structural stall then second issues
    do_reset();
    valid_d = 1; mc_d = 1; regwrite_d = 1; rd_d = 3;
    step();
    rd_d = 4;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("struct_stall%0d", k), 32'(stall_d), 1);
      step();
    end
    #1 check("struct_issue", 32'(stall_d), 0);
    step();
    mc_d = 0; regwrite_d = 0; rd_d = 0; rs_d = {5'd4, 5'd0};
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("rd4_stall%0d", k), 32'(stall_d), 1);
      step();
    end
    #1 check("rd4_release", 32'(stall_d), 0);
    check("b2b_cnt", 32'(stall_cycles), 8);

    // WAW on pending destination
    do_reset();
    valid_d = 1; mc_d = 1; regwrite_d = 1; rd_d = 6;
    step();
    mc_d = 0;
    #1 check("waw_stall", 32'(stall_d), 1);
    clear_inputs();

    // Branch beats load-use and blocks issue
    do_reset();
    rd_e = 7; memread_e = 1; rs_d = {5'd7, 5'd0}; valid_d = 1;
    mc_d = 1; regwrite_d = 1; rd_d = 12; branch_taken_e = 1;
    #1 ctl("br", 0, 0, 1, 1);
    step();
    clear_inputs();
    #1 check("br_no_issue", 32'(mc_busy), 0);
    check("br_cnt", 32'(stall_cycles), 0);

    // Reset in the middle of a countdown
    do_reset();
    valid_d = 1; mc_d = 1; regwrite_d = 1; rd_d = 9;
    step();
    mc_d = 0; regwrite_d = 0; rd_d = 0; rs_d = {5'd0, 5'd9};
    step();
    step();
    check("mid_busy", 32'(mc_busy), 1);
    check("mid_cnt", 32'(stall_cycles), 2);
    rst_n = 1'b0;
    #1 check("arst_busy", 32'(mc_busy), 0);
    check("arst_cnt", 32'(stall_cycles), 0);
    check("arst_stall", 32'(stall_d), 0);
    rst_n = 1'b1;
    step();
    check("post_rst_stall", 32'(stall_d), 0);

    // Counter saturation
    do_reset();
    rd_e = 7; memread_e = 1; rs_d = {5'd0, 5'd7}; valid_d = 1;
    for (int k = 0; k < 14; k++) step();
    check("sat_14", 32'(stall_cycles), 14);
    step();
    check("sat_15", 32'(stall_cycles), 15);
    for (int k = 0; k < 5; k++) step();
    check("sat_hold", 32'(stall_cycles), 15);
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard unit for the pipelined RISC-V core.
- Generates per-operand forwarding selects for Execute, and detects load-use hazards and multi-cycle (MUL/DIV) RAW, WAW and structural hazards through a per-register countdown scoreboard.
- Drives the stall and flush controls for Fetch, Decode and Execute, and keeps a saturating stall-cycle counter.
- Sits beside the datapath. Its forward selects drive the existing Execute operand muxes.

Parameters:
- REG_ADDR_WIDTH, 5, architectural register index width; 2**REG_ADDR_WIDTH registers.
- NUM_SRC, 2, source operands per instruction (2 or 3).
- MC_LAT, 4, multi-cycle unit latency in cycles from issue to writeback-ready; legal range 2..15.
- CNT_WIDTH, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- rs_d  in  NUM_SRC*REG_ADDR_WIDTH  Decode source registers; operand i occupies bits [i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH].
- rs_e  in  NUM_SRC*REG_ADDR_WIDTH  Execute source registers.
- rd_d  in  REG_ADDR_WIDTH  Decode destination.
- regwrite_d  in  1  Decode instruction writes rd_d.
- mc_d  in  1  Decode instruction is a multi-cycle op.
- valid_d  in  1  Decode holds a real instruction.
- rd_e  in  REG_ADDR_WIDTH  Execute destination.
- memread_e  in  1  Execute instruction is a load.
- rd_m  in  REG_ADDR_WIDTH  Memory-stage destination.
- regwrite_m  in  1  Memory-stage instruction writes rd_m.
- rd_w  in  REG_ADDR_WIDTH  Writeback destination.
- regwrite_w  in  1  Writeback instruction writes rd_w.
- branch_taken_e  in  1  taken branch or jump resolved in Execute.
- forward_e  out  2*NUM_SRC  per-operand select: 00 register file, 01 ResultW, 10 ALUResultM.
- stall_f  out  1  hold PC.
- stall_d  out  1  hold the F/D register.
- flush_d  out  1  clear the F/D register.
- flush_e  out  1  clear the D/E register (insert bubble).
- mc_busy  out  1  any scoreboard entry nonzero.
- stall_cycles  out  CNT_WIDTH  saturating count of stall cycles.

Behaviour:
- Reset: all scoreboard counters cleared to 0; stall_cycles = 0; mc_busy = 0. Reset is asynchronous on assertion. State is reset only; all other outputs are combinational from inputs and state.
- Forwarding, per operand i, combinational:
  - If regwrite_m and rd_m != 0 and rd_m == rs_e[i], select 10.
  - Else if regwrite_w and rd_w != 0 and rd_w == rs_e[i], select 01.
  - Else select 00.
  - Memory stage has priority over Writeback. Register x0 is never forwarded.
- Load-use: memread_e, rd_e != 0, and rd_e equals any nonzero rs_d[i] with valid_d set.
- MC RAW: valid_d and any nonzero rs_d[i] whose scoreboard counter is nonzero.
- MC WAW: valid_d, regwrite_d, rd_d != 0, and scoreboard counter[rd_d] nonzero.
- MC structural: valid_d, mc_d, and mc_busy set. The multi-cycle unit is unpipelined.
- Stall condition: load-use OR RAW OR WAW OR structural.
- Stall response: stall_f = stall_d = flush_e = 1 for that cycle.
- Branch: branch_taken_e forces flush_d = flush_e = 1 and stall_f = stall_d = 0. Branch wins over a simultaneous stall because the Decode instruction is discarded.
- Issue event: valid_d & mc_d & regwrite_d & rd_d != 0 & !stall_d & !branch_taken_e.
- Scoreboard update each cycle:
  - On an issue event, counter[rd_d] <= MC_LAT.
  - Otherwise every nonzero counter decrements by 1 and saturates at 0.
  - A register reaching 0 is readable through normal forwarding/regfile the next cycle.
- stall_cycles increments on every cycle stall_d = 1 and holds at all-ones.
- Reset mid-operation clears all pending entries immediately. The pipeline is assumed flushed by the same reset.

Decomposition:
- hazard_pkg:
  - fwd_sel_t enum (FWD_REG = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10).
  - Localparam SB_W = $clog2(MC_LAT+1) computed in the module.
- One sub-module, hazard_fwd_sel: a single-operand forwarding comparator. It is instantiated NUM_SRC times via generate.

Test Plan:
- Set rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1, rs_e[0]=5 -> forward_e[1:0]=10. Then clear regwrite_m -> 01. Then set rs_e[0]=0 with rd_m=0 -> 00.
- Load in E with rd_e=7, memread_e=1, rs_d[1]=7, valid_d=1 -> stall_f/stall_d/flush_e=1 for exactly one cycle; stall_cycles becomes 1.
- Issue MC op rd_d=9 with MC_LAT=4, then a dependent rs_d[0]=9 -> stall held 4 cycles while mc_busy=1; released on cycle 5; stall_cycles=4.
- Two back-to-back MC ops (rd 3, then rd 4) -> second stalls until counter[3] reaches 0, then issues; counter[4] loads 4.
- branch_taken_e=1 concurrent with a load-use hazard -> flush_d=flush_e=1, stall_f=stall_d=0, no scoreboard load, stall_cycles unchanged.
- Assert rst_n=0 with counter[9]=2 mid-countdown -> mc_busy=0 and stall_cycles=0 immediately; no stall after release. Force the counter to saturate -> holds at all-ones.
